uart_cmd_parser: RTL and testbench

//   Sequences the byte stream from the UART receiver (dout/rx_done) into register-bus commands.

---
 rtl/uart_cmd_parser.sv | 105 ++++++++++
 tb/tb_uart_cmd_parser.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Turns the UART receiver byte stream into register-bus write/read strobes.
// Frame: SYNC, CMD, [DATA_HI, DATA_LO], CSUM. Bad checksums and stalled frames raise 1-cycle error pulses.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [6:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  output logic        busy,
  output logic        err_csum,
  output logic        err_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DHI, S_DLO, S_CSUM} state_t;

  // Timeout fires on the edge where the gap counter would reach TIMEOUT_CYCLES-1.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

  state_t          state;
  logic [7:0]      cmd, dhi, dlo;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      exp_csum;

  assign exp_csum = cmd[7] ? (cmd ^ dhi ^ dlo) : cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd         <= '0;
      dhi         <= '0;
      dlo         <= '0;
      to_cnt      <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;

      if (state == S_IDLE || rx_valid) to_cnt <= '0;
      else                             to_cnt <= to_cnt + TO_W'(1);

      if (rx_valid) begin
        unique case (state)
          S_IDLE: if (rx_byte == SYNC_BYTE) begin
            state <= S_CMD;
            busy  <= 1'b1;
          end
          S_CMD: begin
            cmd   <= rx_byte;
            state <= rx_byte[7] ? S_DHI : S_CSUM;
          end
          S_DHI: begin
            dhi   <= rx_byte;
            state <= S_DLO;
          end
          S_DLO: begin
            dlo   <= rx_byte;
            state <= S_CSUM;
          end
          S_CSUM: begin
            if (rx_byte == exp_csum) begin
              reg_addr <= cmd[6:0];
              if (cmd[7]) begin
                reg_wdata <= {dhi, dlo};
                reg_wr_en <= 1'b1;
              end else begin
                reg_rd_en <= 1'b1;
              end
            end else begin
              err_csum <= 1'b1;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (state != S_IDLE && to_cnt == TO_LAST) begin
        err_timeout <= 1'b1;
        state       <= S_IDLE;
        busy        <= 1'b0;
        cmd         <= '0;
        dhi         <= '0;
        dlo         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed frames against a queue-based frame model checked every cycle, plus literal spot checks.
module tb_uart_cmd_parser;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr_en, reg_rd_en, busy, err_csum, err_timeout;

  uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en), .busy(busy), .err_csum(err_csum), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;
  int to_pulses = 0;

  // Frame model: bytes collected so far and idle cycles since the last byte.
  logic [7:0]  frame[$];
  int          gap = 0;
  logic [6:0]  m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic        m_wr = 0, m_rd = 0, m_csum = 0, m_to = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame.delete();
      gap = 0; m_addr = '0; m_wdata = '0;
      m_wr = 0; m_rd = 0; m_csum = 0; m_to = 0;
    end else begin
      m_wr = 0; m_rd = 0; m_csum = 0; m_to = 0;
      if (rx_valid) begin
        gap = 0;
        if (frame.size() == 0) begin
          if (rx_byte == 8'hA5) frame.push_back(rx_byte);
        end else begin
          frame.push_back(rx_byte);
          if (frame.size() == (frame[1][7] ? 5 : 3)) begin
            if (frame[1][7]) begin
              if ((frame[1] ^ frame[2] ^ frame[3]) == frame[4]) begin
                m_addr = frame[1][6:0]; m_wdata = {frame[2], frame[3]}; m_wr = 1;
              end else m_csum = 1;
            end else begin
              if (frame[1] == frame[2]) begin
                m_addr = frame[1][6:0]; m_rd = 1;
              end else m_csum = 1;
            end
            frame.delete();
          end
        end
      end else if (frame.size() > 0) begin
        gap++;
        if (gap == TO - 1) begin
          m_to = 1; frame.delete(); gap = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if ({reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy, err_csum, err_timeout} !==
        {m_addr, m_wdata, m_wr, m_rd, (frame.size() > 0), m_csum, m_to}) begin
      $display("FAIL cycle_model t=%0t got addr=%h wdata=%h wr=%b rd=%b busy=%b ec=%b et=%b want addr=%h wdata=%h wr=%b rd=%b busy=%b ec=%b et=%b",
               $time, reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy, err_csum, err_timeout,
               m_addr, m_wdata, m_wr, m_rd, frame.size() > 0, m_csum, m_to);
    end else pass_cnt++;
    total++;
    if ((32'(reg_wr_en) + 32'(reg_rd_en) + 32'(err_csum) + 32'(err_timeout)) > 1) begin
      $display("FAIL one_hot t=%0t more than one pulse", $time);
    end else pass_cnt++;
    total++;
    if (err_timeout) to_pulses++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) $display("FAIL %s got=%h want=%h", name, got, want);
    else pass_cnt++;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); #1;
    rx_valid = 1'b1; rx_byte = b;
    @(negedge clk); #1;
    rx_valid = 1'b0;
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy, err_csum, err_timeout}, 0);
    #1 rst_n = 1'b1;

    // 1: write
    send(8'hA5); send(8'h81);
    check("busy_mid_frame", busy, 1);
    send(8'h12); send(8'h34); send(8'hA7);
    check("t1_wr_en", reg_wr_en, 1);
    check("t1_addr", reg_addr, 7'h01);
    check("t1_wdata", reg_wdata, 16'h1234);
    check("t1_busy", busy, 0);
    // 2: read
    send(8'hA5); send(8'h05); send(8'h05);
    check("t2_rd_en", reg_rd_en, 1);
    check("t2_wr_en", reg_wr_en, 0);
    check("t2_addr", reg_addr, 7'h05);
    check("t2_wdata", reg_wdata, 16'h1234);
    // 3: checksum error
    send(8'hA5); send(8'h81); send(8'h12); send(8'h34); send(8'h00);
    check("t3_err_csum", err_csum, 1);
    check("t3_no_strobe", {reg_wr_en, reg_rd_en}, 0);
    check("t3_addr_kept", reg_addr, 7'h05);
    check("t3_wdata_kept", reg_wdata, 16'h1234);
    // 4: timeout 19 cycles after the 81 byte, then a normal read
    send(8'hA5); send(8'h81);
    n = 0;
    while (!err_timeout && n < 100) begin @(negedge clk); #1; n++; end
    check("t4_timeout_latency", n, 19);
    check("t4_idle_after", busy, 0);
    send(8'hA5); send(8'h05); send(8'h05);
    check("t4_read_after", reg_rd_en, 1);
    // byte landing on the terminal-count cycle wins
    to_pulses = 0;
    send(8'hA5); send(8'h81);
    repeat (17) @(negedge clk);
    send(8'h12); send(8'h34); send(8'hA7);
    check("tc_byte_wins", reg_wr_en, 1);
    check("tc_no_timeout", to_pulses, 0);
    // 5: junk then read
    send(8'h00); send(8'hFF); send(8'h5A);
    check("t5_junk_idle", busy, 0);
    send(8'hA5); send(8'h05); send(8'h05);
    check("t5_rd_en", reg_rd_en, 1);
    // SYNC value as ordinary data, back-to-back bytes
    @(negedge clk); #1;
    rx_valid = 1'b1;
    foreach (frame[i]) ; // no-op keeps frame visible to lint
    rx_byte = 8'hA5; @(negedge clk); #1;
    rx_byte = 8'h80; @(negedge clk); #1;
    rx_byte = 8'hA5; @(negedge clk); #1;
    rx_byte = 8'h00; @(negedge clk); #1;
    rx_byte = 8'h25; @(negedge clk); #1;
    rx_valid = 1'b0;
    check("sync_as_data_wdata", reg_wdata, 16'hA500);
    check("sync_as_data_addr", reg_addr, 7'h00);
    // 6: reset mid-frame
    send(8'hA5); send(8'h81); send(8'h12);
    rst_n = 1'b0; #1;
    check("t6_reset_outputs", {reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy, err_csum, err_timeout}, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    send(8'hA5); send(8'h83); send(8'hBE); send(8'hEF); send(8'h83 ^ 8'hBE ^ 8'hEF);
    check("t6_wr_after_reset", reg_wr_en, 1);
    check("t6_wdata", reg_wdata, 16'hBEEF);
    check("t6_addr", reg_addr, 7'h03);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
